// File: rtl/wm_pkg.sv
// Shared types for the washing-machine program sequencer: phase encoding and preset layout.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package wm_pkg;

    // Encoding is visible on the phase output and must stay stable for the panel logic.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WASH  = 3'd1,
        RINSE = 3'd2,
        SPIN  = 3'd3,
        DONE  = 3'd4
    } phase_t;

    // Preset layout at the default field width. The bank and sequencer rebuild the
    // same field order at their FIELD_W parameter.
    localparam int DEF_FIELD_W = 5;

    typedef struct packed {
        logic [DEF_FIELD_W-1:0] wash;
        logic [DEF_FIELD_W-1:0] rinse;
        logic [DEF_FIELD_W-1:0] spin;
        logic [DEF_FIELD_W-1:0] cloth;
    } wm_fields_t;

    // First phase after 'cur' whose duration is non-zero, in WASH -> RINSE -> SPIN order.
    // Zero-length phases are skipped here, so the sequencer never spends a cycle in them.
    function automatic phase_t next_phase(phase_t cur, logic wash_nz, logic rinse_nz, logic spin_nz);
        phase_t nxt;
        nxt = DONE;
        case (cur)
            IDLE: begin
                if (wash_nz)       nxt = WASH;
                else if (rinse_nz) nxt = RINSE;
                else if (spin_nz)  nxt = SPIN;
            end
            WASH: begin
                if (rinse_nz)      nxt = RINSE;
                else if (spin_nz)  nxt = SPIN;
            end
            RINSE: begin
                if (spin_nz)       nxt = SPIN;
            end
            default: nxt = DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wm_preset_bank.sv
// Preset storage: NUM_PRESETS entries of wash/rinse/spin/cloth, one write port, indexed readback.
// Latency: write lands on the clock edge; *_out is registered (1 cycle); cur_* is a combinational view.
// Backpressure: none; writes presented while busy=1 are dropped.
// Ports: clk, rst (async, active-high); wr_en/busy/preset_sel/*_in write side;
//        cur_* combinational contents of preset_sel (pre-write value); *_out registered readback.
module wm_preset_bank #(
    parameter int NUM_PRESETS = 4,
    parameter int FIELD_W     = 5,
    parameter int PS_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               busy,
    input  logic [PS_W-1:0]    preset_sel,
    input  logic [FIELD_W-1:0] wash_in,
    input  logic [FIELD_W-1:0] rinse_in,
    input  logic [FIELD_W-1:0] spin_in,
    input  logic [FIELD_W-1:0] cloth_in,
    output logic [FIELD_W-1:0] cur_wash,
    output logic [FIELD_W-1:0] cur_rinse,
    output logic [FIELD_W-1:0] cur_spin,
    output logic [FIELD_W-1:0] cur_cloth,
    output logic [FIELD_W-1:0] wash_out,
    output logic [FIELD_W-1:0] rinse_out,
    output logic [FIELD_W-1:0] spin_out,
    output logic [FIELD_W-1:0] cloth_out
);

    typedef struct packed {
        logic [FIELD_W-1:0] wash;
        logic [FIELD_W-1:0] rinse;
        logic [FIELD_W-1:0] spin;
        logic [FIELD_W-1:0] cloth;
    } fields_t;

    fields_t mem [NUM_PRESETS];
    fields_t cur;
    fields_t rd_q;
    logic    sel_ok;

    // Out-of-range indices (non power-of-two NUM_PRESETS) read as zero and never write.
    assign sel_ok = 32'(preset_sel) < 32'(NUM_PRESETS);

    always_comb begin
        cur = '0;
        if (sel_ok) cur = mem[preset_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRESETS; i++) mem[i] <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en && !busy && sel_ok)
                mem[preset_sel] <= '{wash: wash_in, rinse: rinse_in, spin: spin_in, cloth: cloth_in};
            rd_q <= cur;
        end
    end

    assign cur_wash  = cur.wash;
    assign cur_rinse = cur.rinse;
    assign cur_spin  = cur.spin;
    assign cur_cloth = cur.cloth;

    assign wash_out  = rd_q.wash;
    assign rinse_out = rd_q.rinse;
    assign spin_out  = rd_q.spin;
    assign cloth_out = rd_q.cloth;

endmodule

// File: rtl/wm_program_sequencer.sv
// Preset bank plus WASH -> RINSE -> SPIN sequencer with per-phase timed countdown.
// Latency: start to first phase 1 cycle; each phase lasts field*TICKS_PER_UNIT cycles; DONE 1 cycle.
// Backpressure: none; start and writes are ignored while busy, abort always wins.
// Ports: clk, rst (async, active-high); wr_en/preset_sel/*_in preset writes; start/abort/pause control;
//        *_out registered readback of preset_sel; phase/remaining/busy status; motor_on/valve_on/drain_on
//        actuators; done and err single-cycle pulses.
// Build option: define WM_PAUSE_EN to make pause freeze the running program (otherwise pause is ignored).
module wm_program_sequencer
    import wm_pkg::*;
#(
    parameter int NUM_PRESETS    = 4,
    parameter int FIELD_W        = 5,
    parameter int TICKS_PER_UNIT = 8,
    parameter int MAX_LOAD       = 20,
    localparam int PS_W          = $clog2(NUM_PRESETS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [PS_W-1:0]    preset_sel,
    input  logic [FIELD_W-1:0] wash_in,
    input  logic [FIELD_W-1:0] rinse_in,
    input  logic [FIELD_W-1:0] spin_in,
    input  logic [FIELD_W-1:0] cloth_in,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    output logic [FIELD_W-1:0] wash_out,
    output logic [FIELD_W-1:0] rinse_out,
    output logic [FIELD_W-1:0] spin_out,
    output logic [FIELD_W-1:0] cloth_out,
    output logic [2:0]         phase,
    output logic [FIELD_W-1:0] remaining,
    output logic               busy,
    output logic               motor_on,
    output logic               valve_on,
    output logic               drain_on,
    output logic               done,
    output logic               err
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);

    phase_t             state;
    phase_t             start_phase;
    phase_t             step_phase;
    logic [FIELD_W-1:0] cur_wash, cur_rinse, cur_spin, cur_cloth;
    logic [FIELD_W-1:0] work_rinse, work_spin;
    logic [PW-1:0]      presc;
    logic               in_phase;
    logic               hold;
    logic               cloth_bad;

    function automatic logic [FIELD_W-1:0] field_for(phase_t p, logic [FIELD_W-1:0] w,
                                                     logic [FIELD_W-1:0] r, logic [FIELD_W-1:0] s);
        case (p)
            WASH:    return w;
            RINSE:   return r;
            SPIN:    return s;
            default: return '0;
        endcase
    endfunction

    wm_preset_bank #(
        .NUM_PRESETS (NUM_PRESETS),
        .FIELD_W     (FIELD_W),
        .PS_W        (PS_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .busy       (busy),
        .preset_sel (preset_sel),
        .wash_in    (wash_in),
        .rinse_in   (rinse_in),
        .spin_in    (spin_in),
        .cloth_in   (cloth_in),
        .cur_wash   (cur_wash),
        .cur_rinse  (cur_rinse),
        .cur_spin   (cur_spin),
        .cur_cloth  (cur_cloth),
        .wash_out   (wash_out),
        .rinse_out  (rinse_out),
        .spin_out   (spin_out),
        .cloth_out  (cloth_out)
    );

    assign in_phase = (state == WASH) || (state == RINSE) || (state == SPIN);

`ifdef WM_PAUSE_EN
    assign hold = pause && in_phase;
`else
    logic pause_unused;
    assign pause_unused = pause;
    assign hold = 1'b0;
`endif

    // cur_* is the stored value before any same-cycle write, so start+wr_en runs the old program.
    assign cloth_bad   = (cur_cloth == '0) || (32'(cur_cloth) > 32'(MAX_LOAD));
    assign start_phase = next_phase(IDLE, cur_wash != '0, cur_rinse != '0, cur_spin != '0);
    assign step_phase  = next_phase(state, 1'b0, work_rinse != '0, work_spin != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            presc      <= '0;
            work_rinse <= '0;
            work_spin  <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (abort) begin
                // Also masks a same-cycle start in IDLE: no run, no err.
                state     <= IDLE;
                remaining <= '0;
                presc     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cloth_bad) begin
                                err <= 1'b1;
                            end else begin
                                // WASH is entered straight from the bank; only later phases need a copy.
                                work_rinse <= cur_rinse;
                                work_spin  <= cur_spin;
                                state      <= start_phase;
                                remaining  <= field_for(start_phase, cur_wash, cur_rinse, cur_spin);
                                presc      <= '0;
                            end
                        end
                    end
                    WASH, RINSE, SPIN: begin
                        if (!hold) begin
                            if (presc == PRESC_LAST) begin
                                presc <= '0;
                                if (remaining == FIELD_W'(1)) begin
                                    state     <= step_phase;
                                    remaining <= field_for(step_phase, '0, work_rinse, work_spin);
                                end else begin
                                    remaining <= remaining - FIELD_W'(1);
                                end
                            end else begin
                                presc <= presc + PW'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        remaining <= '0;
                        presc     <= '0;
                    end
                endcase
            end
        end
    end

    assign phase    = state;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign motor_on = in_phase && !hold;
    assign valve_on = ((state == WASH) || (state == RINSE)) && !hold;
    assign drain_on = (state == SPIN);

endmodule

// File: tb/tb_wm_program_sequencer.sv
module tb_wm_program_sequencer;

    localparam int NP   = 4;
    localparam int FW   = 5;
    localparam int TPU  = 2;
    localparam int ML   = 20;
    localparam int PS_W = 2;

    logic          clk, rst;
    logic          wr_en, start, abort, pause;
    logic [PS_W-1:0] preset_sel;
    logic [FW-1:0] wash_in, rinse_in, spin_in, cloth_in;
    logic [FW-1:0] wash_out, rinse_out, spin_out, cloth_out;
    logic [2:0]    phase;
    logic [FW-1:0] remaining;
    logic          busy, motor_on, valve_on, drain_on, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int nw, nr, ns, nd, nb, nsd;

    wm_program_sequencer #(
        .NUM_PRESETS    (NP),
        .FIELD_W        (FW),
        .TICKS_PER_UNIT (TPU),
        .MAX_LOAD       (ML)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .preset_sel (preset_sel),
        .wash_in    (wash_in),
        .rinse_in   (rinse_in),
        .spin_in    (spin_in),
        .cloth_in   (cloth_in),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .wash_out   (wash_out),
        .rinse_out  (rinse_out),
        .spin_out   (spin_out),
        .cloth_out  (cloth_out),
        .phase      (phase),
        .remaining  (remaining),
        .busy       (busy),
        .motor_on   (motor_on),
        .valve_on   (valve_on),
        .drain_on   (drain_on),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rb();
        return {12'd0, wash_out, rinse_out, spin_out, cloth_out};
    endfunction

    function automatic logic [31:0] pk(input int w, input int r, input int s, input int c);
        logic [FW-1:0] fw, fr, fs, fc;
        fw = FW'(w); fr = FW'(r); fs = FW'(s); fc = FW'(c);
        return {12'd0, fw, fr, fs, fc};
    endfunction

    task automatic write_preset(input int sel, input int w, input int r, input int s, input int c);
        preset_sel = PS_W'(sel);
        wash_in = FW'(w); rinse_in = FW'(r); spin_in = FW'(s); cloth_in = FW'(c);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_prog(input int sel);
        preset_sel = PS_W'(sel);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tallies every busy cycle from the current sample until the sequencer returns to IDLE.
    task automatic run_count(output int cw, output int cr, output int cs, output int cd,
                             output int cb, output int csd);
        cw = 0; cr = 0; cs = 0; cd = 0; cb = 0; csd = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            cb++;
            case (phase)
                3'd1: cw++;
                3'd2: cr++;
                3'd3: begin
                    cs++;
                    if (drain_on && motor_on && !valve_on) csd++;
                end
                default: ;
            endcase
            if (done) cd++;
            tick();
        end
        check("run_ends_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        preset_sel = '0; wash_in = '0; rinse_in = '0; spin_in = '0; cloth_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_phase", phase, 0);
        check("rst_remaining", remaining, 0);
        check("rst_flags", {busy, motor_on, valve_on, drain_on, done, err}, 0);
        check("rst_readback", rb(), 0);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin
            preset_sel = PS_W'(i);
            tick();
            check($sformatf("rst_preset%0d", i), rb(), 0);
        end

        // Full program: 3/2/1 units at 2 ticks each plus DONE -> 13 busy cycles.
        write_preset(2, 3, 2, 1, 10);
        check("rb_before_latency", rb(), 0);
        tick();
        check("rb_p2", rb(), pk(3, 2, 1, 10));
        start_prog(2);
        check("p2_first_phase", phase, 1);
        check("p2_first_rem", remaining, 3);
        check("p2_wash_act", {motor_on, valve_on, drain_on}, 3'b110);
        tick(); tick();
        check("p2_rem_after_unit", remaining, 2);
        run_count(nw, nr, ns, nd, nb, nsd);
        check("p2_wash_cycles", nw + 2, 6);
        check("p2_rinse_cycles", nr, 4);
        check("p2_spin_cycles", ns, 2);
        check("p2_spin_act", nsd, 2);
        check("p2_done_pulses", nd, 1);
        check("p2_busy_total", nb + 2, 13);
        check("p2_end_flags", {motor_on, valve_on, drain_on, done}, 0);

        // Wash and spin skipped with no idle cycle.
        write_preset(1, 0, 2, 0, 5);
        start_prog(1);
        check("p1_first_phase", phase, 2);
        check("p1_first_rem", remaining, 2);
        run_count(nw, nr, ns, nd, nb, nsd);
        check("p1_counts", {nw[7:0], nr[7:0], ns[7:0], nd[7:0]}, {8'd0, 8'd4, 8'd0, 8'd1});
        check("p1_busy_total", nb, 5);

        // Cloth load limits.
        write_preset(3, 1, 1, 1, 0);
        start_prog(3);
        check("cloth0_err", {err, busy}, 2'b10);
        check("cloth0_phase", phase, 0);
        tick();
        check("cloth0_err_pulse", err, 0);
        write_preset(3, 1, 1, 1, 21);
        start_prog(3);
        check("cloth21_err", {err, busy}, 2'b10);
        write_preset(0, 0, 0, 0, 20);
        start_prog(0);
        check("allzero_done", {29'd0, phase}, 4);
        check("allzero_flags", {done, err, busy}, 3'b101);
        tick();
        check("allzero_idle", {phase, done}, 0);

        // Abort in the second RINSE cycle.
        start_prog(2);
        repeat (6) tick();
        check("abort_rinse_c1", phase, 2);
        tick();
        check("abort_rinse_c2", {phase, remaining}, {3'd2, 5'd2});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", phase, 0);
        check("abort_flags", {busy, motor_on, valve_on, drain_on, done}, 0);
        check("abort_rem", remaining, 0);
        tick();
        check("abort_no_done", done, 0);

        // Abort beats start in IDLE.
        preset_sel = 2'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {phase, busy, err}, 0);

        // Writes while running are dropped.
        start_prog(1);
        write_preset(1, 7, 7, 7, 7);
        run_count(nw, nr, ns, nd, nb, nsd);
        check("busy_write_run", nb, 4);
        tick();
        check("busy_write_ignored", rb(), pk(0, 2, 0, 5));

        // start and wr_en together: old contents run, new contents stored.
        preset_sel = 2'd1;
        wash_in = 5'd1; rinse_in = 5'd0; spin_in = 5'd0; cloth_in = 5'd5;
        wr_en = 1'b1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("sw_old_phase", phase, 2);
        run_count(nw, nr, ns, nd, nb, nsd);
        check("sw_old_counts", {nw[7:0], nr[7:0], nb[7:0]}, {8'd0, 8'd4, 8'd5});
        tick();
        check("sw_new_stored", rb(), pk(1, 0, 0, 5));

        // Pause for 5 cycles at the start of WASH.
        start_prog(2);
        pause = 1'b1;
        #1;
`ifdef WM_PAUSE_EN
        check("pause_motor", {motor_on, valve_on}, 2'b00);
`else
        check("pause_motor", {motor_on, valve_on}, 2'b11);
`endif
        repeat (5) tick();
        check("pause_phase", phase, 1);
`ifdef WM_PAUSE_EN
        check("pause_rem", remaining, 3);
`else
        check("pause_rem", remaining, 1);
`endif
        pause = 1'b0;
        run_count(nw, nr, ns, nd, nb, nsd);
`ifdef WM_PAUSE_EN
        check("pause_total", nb + 5, 18);
`else
        check("pause_total", nb + 5, 13);
`endif

        // Reset mid-run: immediate IDLE and presets cleared.
        start_prog(2);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst_idle", {phase, busy, motor_on}, 0);
        #2;
        rst = 1'b0;
        preset_sel = 2'd2;
        tick();
        check("midrst_cleared", rb(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
